// File: rtl/mseq_pkg.sv
// Shared definitions for the multi-cycle microcode sequencer: state encoding,
// opcode constants and the strobe bundle produced by the decoder.
package mseq_pkg;

    typedef enum logic [2:0] {
        S_IF       = 3'd0,
        S_ID       = 3'd1,
        S_EX       = 3'd2,
        S_MEM      = 3'd3,
        S_WB       = 3'd4,
        S_BR_TAKEN = 3'd5,
        S_HALT     = 3'd6
    } mseq_state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    typedef struct packed {
        logic ir_from_mem_pc;
        logic a_from_rf_rs1;
        logic b_from_rf_rs2;
        logic aluout_from_pcp4;
        logic aluout_from_apb;
        logic rf_rd_from_aluout;
        logic pc_from_pcp4;
        logic aluout_from_apimm;
        logic mdr_from_mem_aluout;
        logic rf_rd_from_mdr;
        logic mem_aluout_from_b;
        logic pc_from_aluout;
        logic pc_from_pcpimm;
        logic pc_from_apimm;
    } mseq_strobes_t;

endpackage

// File: rtl/mseq_next_state.sv
// Next-state function of the microcode sequencer (pure combinational).
import mseq_pkg::*;

module mseq_next_state (
    input  mseq_state_t state,
    input  logic [6:0]  opcode,
    input  logic        bcond,
    input  logic        halt_req,
    output mseq_state_t next_state
);

    // Successor state selection from current state and decoded opcode
    always_comb begin
        next_state = S_IF;
        case (state)
            S_IF: next_state = S_ID;
            S_ID: begin
                if ((opcode == OP_ECALL) && halt_req) begin
                    next_state = S_HALT;
                end else begin
                    next_state = S_EX;
                end
            end
            S_EX: begin
                case (opcode)
                    OP_RTYPE, OP_OPIMM: next_state = S_WB;
                    OP_LOAD, OP_STORE:  next_state = S_MEM;
                    OP_BRANCH: begin
                        if (bcond) begin
                            next_state = S_BR_TAKEN;
                        end else begin
                            next_state = S_IF;
                        end
                    end
                    default:            next_state = S_IF;
                endcase
            end
            S_MEM: begin
                if (opcode == OP_LOAD) begin
                    next_state = S_WB;
                end else begin
                    next_state = S_IF;
                end
            end
            S_WB:       next_state = S_IF;
            S_BR_TAKEN: next_state = S_IF;
            S_HALT:     next_state = S_HALT;
            default:    next_state = S_IF;
        endcase
    end

endmodule

// File: rtl/microcode_sequencer.sv
// Multi-cycle control sequencer: state register plus Moore strobe decode.
// Optional retired-instruction counter enabled by defining MSEQ_INSTR_CNT_EN.
import mseq_pkg::*;

module microcode_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [6:0]  opcode,
    input  logic        bcond,
    input  logic        halt_req,
    output logic        to_IR_from_MEM_PC,
    output logic        to_A_from_RF_RS1,
    output logic        to_B_from_RF_RS2,
    output logic        to_ALUOut_from_PCp4,
    output logic        to_ALUOut_from_ApB,
    output logic        to_RF_rd_from_ALUOut,
    output logic        to_PC_from_PCp4,
    output logic        to_ALUOut_from_Apimm,
    output logic        to_MDR_from_MEM_ALUOut,
    output logic        to_RF_rd_from_MDR,
    output logic        to_MEM_ALUOut_from_B,
    output logic        to_PC_from_ALUOut,
    output logic        to_PC_from_PCpimm,
    output logic        to_PC_from_Apimm,
    output logic        is_halted,
`ifdef MSEQ_INSTR_CNT_EN
    output logic [31:0] instr_cnt,
`endif
    output logic [2:0]  state
);

    mseq_state_t   state_r;
    mseq_state_t   next_state_s;
    mseq_strobes_t stb_s;
    mseq_strobes_t stb_gated_s;

    mseq_next_state u_next_state (
        .state      (state_r),
        .opcode     (opcode),
        .bcond      (bcond),
        .halt_req   (halt_req),
        .next_state (next_state_s)
    );

    // State register; asynchronous reset aborts any instruction in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IF;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Moore strobe decode from current state and opcode
    always_comb begin
        stb_s = '0;
        case (state_r)
            S_IF: stb_s.ir_from_mem_pc = 1'b1;
            S_ID: begin
                stb_s.a_from_rf_rs1    = 1'b1;
                stb_s.b_from_rf_rs2    = 1'b1;
                stb_s.aluout_from_pcp4 = 1'b1;
            end
            S_EX: begin
                case (opcode)
                    OP_RTYPE:                    stb_s.aluout_from_apb   = 1'b1;
                    OP_OPIMM, OP_LOAD, OP_STORE: stb_s.aluout_from_apimm = 1'b1;
                    OP_BRANCH:                   stb_s.pc_from_aluout    = 1'b1;
                    OP_JAL: begin
                        stb_s.rf_rd_from_aluout = 1'b1;
                        stb_s.pc_from_pcpimm    = 1'b1;
                    end
                    OP_JALR: begin
                        stb_s.rf_rd_from_aluout = 1'b1;
                        stb_s.pc_from_apimm     = 1'b1;
                    end
                    // ECALL without halt and unknown opcodes retire as a NOP
                    default:                     stb_s.pc_from_pcp4      = 1'b1;
                endcase
            end
            S_MEM: begin
                case (opcode)
                    OP_LOAD:  stb_s.mdr_from_mem_aluout = 1'b1;
                    OP_STORE: begin
                        stb_s.mem_aluout_from_b = 1'b1;
                        stb_s.pc_from_pcp4      = 1'b1;
                    end
                    default:  stb_s = '0;
                endcase
            end
            S_WB: begin
                case (opcode)
                    OP_LOAD: begin
                        stb_s.rf_rd_from_mdr = 1'b1;
                        stb_s.pc_from_pcp4   = 1'b1;
                    end
                    OP_RTYPE, OP_OPIMM: begin
                        stb_s.rf_rd_from_aluout = 1'b1;
                        stb_s.pc_from_pcp4      = 1'b1;
                    end
                    default: stb_s = '0;
                endcase
            end
            S_BR_TAKEN: stb_s.pc_from_pcpimm = 1'b1;
            S_HALT:     stb_s = '0;
            default:    stb_s = '0;
        endcase
    end

    // Strobes are forced low combinationally while reset is asserted
    always_comb begin
        if (reset_n) begin
            stb_gated_s = stb_s;
        end else begin
            stb_gated_s = '0;
        end
    end

    assign to_IR_from_MEM_PC      = stb_gated_s.ir_from_mem_pc;
    assign to_A_from_RF_RS1       = stb_gated_s.a_from_rf_rs1;
    assign to_B_from_RF_RS2       = stb_gated_s.b_from_rf_rs2;
    assign to_ALUOut_from_PCp4    = stb_gated_s.aluout_from_pcp4;
    assign to_ALUOut_from_ApB     = stb_gated_s.aluout_from_apb;
    assign to_RF_rd_from_ALUOut   = stb_gated_s.rf_rd_from_aluout;
    assign to_PC_from_PCp4        = stb_gated_s.pc_from_pcp4;
    assign to_ALUOut_from_Apimm   = stb_gated_s.aluout_from_apimm;
    assign to_MDR_from_MEM_ALUOut = stb_gated_s.mdr_from_mem_aluout;
    assign to_RF_rd_from_MDR      = stb_gated_s.rf_rd_from_mdr;
    assign to_MEM_ALUOut_from_B   = stb_gated_s.mem_aluout_from_b;
    assign to_PC_from_ALUOut      = stb_gated_s.pc_from_aluout;
    assign to_PC_from_PCpimm      = stb_gated_s.pc_from_pcpimm;
    assign to_PC_from_Apimm       = stb_gated_s.pc_from_apimm;
    assign is_halted              = reset_n && (state_r == S_HALT);
    assign state                  = state_r;

`ifdef MSEQ_INSTR_CNT_EN
    logic [31:0] instr_cnt_r;

    // Counts instructions retired (entries into IF); cleared and held on halt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_cnt_r <= 32'd0;
        end else if ((state_r == S_HALT) || (next_state_s == S_HALT)) begin
            instr_cnt_r <= 32'd0;
        end else if (next_state_s == S_IF) begin
            instr_cnt_r <= instr_cnt_r + 32'd1;
        end else begin
            instr_cnt_r <= instr_cnt_r;
        end
    end

    assign instr_cnt = instr_cnt_r;
`endif

endmodule

// File: tb/tb_microcode_sequencer.sv
// Table-driven directed bench for microcode_sequencer, plus hand-written
// sequences for mid-instruction reset and halt.
module tb_microcode_sequencer;

    localparam logic [2:0] ST_IF  = 3'd0;
    localparam logic [2:0] ST_ID  = 3'd1;
    localparam logic [2:0] ST_EX  = 3'd2;
    localparam logic [2:0] ST_MEM = 3'd3;
    localparam logic [2:0] ST_WB  = 3'd4;
    localparam logic [2:0] ST_BRT = 3'd5;
    localparam logic [2:0] ST_HLT = 3'd6;

    localparam logic [13:0] K_IR    = 14'h2000;
    localparam logic [13:0] K_A     = 14'h1000;
    localparam logic [13:0] K_B     = 14'h0800;
    localparam logic [13:0] K_ALP4  = 14'h0400;
    localparam logic [13:0] K_APB   = 14'h0200;
    localparam logic [13:0] K_RFALU = 14'h0100;
    localparam logic [13:0] K_PCP4  = 14'h0080;
    localparam logic [13:0] K_APIMM = 14'h0040;
    localparam logic [13:0] K_MDR   = 14'h0020;
    localparam logic [13:0] K_RFMDR = 14'h0010;
    localparam logic [13:0] K_MEMB  = 14'h0008;
    localparam logic [13:0] K_PCALU = 14'h0004;
    localparam logic [13:0] K_PCPIM = 14'h0002;
    localparam logic [13:0] K_PCAIM = 14'h0001;
    localparam logic [13:0] K_IDST  = 14'h1C00;

    localparam logic [6:0] O_R   = 7'b0110011;
    localparam logic [6:0] O_I   = 7'b0010011;
    localparam logic [6:0] O_LD  = 7'b0000011;
    localparam logic [6:0] O_ST  = 7'b0100011;
    localparam logic [6:0] O_BR  = 7'b1100011;
    localparam logic [6:0] O_JAL = 7'b1101111;
    localparam logic [6:0] O_JR  = 7'b1100111;
    localparam logic [6:0] O_EC  = 7'b1110011;
    localparam logic [6:0] O_BAD = 7'b1111111;

    typedef struct {
        logic [6:0]  op;
        logic        bc;
        logic        hr;
        logic [2:0]  st;
        logic [13:0] stb;
        logic        hl;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic        bcond = 1'b0;
    logic        halt_req = 1'b0;
    logic        to_IR_from_MEM_PC, to_A_from_RF_RS1, to_B_from_RF_RS2;
    logic        to_ALUOut_from_PCp4, to_ALUOut_from_ApB, to_RF_rd_from_ALUOut;
    logic        to_PC_from_PCp4, to_ALUOut_from_Apimm, to_MDR_from_MEM_ALUOut;
    logic        to_RF_rd_from_MDR, to_MEM_ALUOut_from_B, to_PC_from_ALUOut;
    logic        to_PC_from_PCpimm, to_PC_from_Apimm, is_halted;
    logic [2:0]  state;
`ifdef MSEQ_INSTR_CNT_EN
    logic [31:0] instr_cnt;
`endif
    logic [13:0] act_stb;
    logic [31:0] exp_cnt = 32'd0;
    int          nvec = 0;
    int          nerr = 0;
    vec_t        vecs[$];

    always #5 clk = ~clk;

    microcode_sequencer dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .opcode                 (opcode),
        .bcond                  (bcond),
        .halt_req               (halt_req),
        .to_IR_from_MEM_PC      (to_IR_from_MEM_PC),
        .to_A_from_RF_RS1       (to_A_from_RF_RS1),
        .to_B_from_RF_RS2       (to_B_from_RF_RS2),
        .to_ALUOut_from_PCp4    (to_ALUOut_from_PCp4),
        .to_ALUOut_from_ApB     (to_ALUOut_from_ApB),
        .to_RF_rd_from_ALUOut   (to_RF_rd_from_ALUOut),
        .to_PC_from_PCp4        (to_PC_from_PCp4),
        .to_ALUOut_from_Apimm   (to_ALUOut_from_Apimm),
        .to_MDR_from_MEM_ALUOut (to_MDR_from_MEM_ALUOut),
        .to_RF_rd_from_MDR      (to_RF_rd_from_MDR),
        .to_MEM_ALUOut_from_B   (to_MEM_ALUOut_from_B),
        .to_PC_from_ALUOut      (to_PC_from_ALUOut),
        .to_PC_from_PCpimm      (to_PC_from_PCpimm),
        .to_PC_from_Apimm       (to_PC_from_Apimm),
        .is_halted              (is_halted),
`ifdef MSEQ_INSTR_CNT_EN
        .instr_cnt              (instr_cnt),
`endif
        .state                  (state)
    );

    assign act_stb = {to_IR_from_MEM_PC, to_A_from_RF_RS1, to_B_from_RF_RS2,
                      to_ALUOut_from_PCp4, to_ALUOut_from_ApB, to_RF_rd_from_ALUOut,
                      to_PC_from_PCp4, to_ALUOut_from_Apimm, to_MDR_from_MEM_ALUOut,
                      to_RF_rd_from_MDR, to_MEM_ALUOut_from_B, to_PC_from_ALUOut,
                      to_PC_from_PCpimm, to_PC_from_Apimm};

    task automatic add(input logic [6:0] op, input logic bc, input logic hr,
                       input logic [2:0] st, input logic [13:0] stb);
        vec_t v;
        v.op = op; v.bc = bc; v.hr = hr; v.st = st; v.stb = stb;
        v.hl = (st == ST_HLT);
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [2:0] st,
                         input logic [13:0] stb, input logic hl);
        nvec++;
        if (state !== st) begin
            nerr++;
            $display("FAIL %s state: got %0d expected %0d", nm, state, st);
        end
        nvec++;
        if (act_stb !== stb) begin
            nerr++;
            $display("FAIL %s strobes: got %b expected %b", nm, act_stb, stb);
        end
        nvec++;
        if (is_halted !== hl) begin
            nerr++;
            $display("FAIL %s is_halted: got %b expected %b", nm, is_halted, hl);
        end
`ifdef MSEQ_INSTR_CNT_EN
        nvec++;
        if (instr_cnt !== exp_cnt) begin
            nerr++;
            $display("FAIL %s instr_cnt: got %0d expected %0d", nm, instr_cnt, exp_cnt);
        end
`endif
    endtask

    task automatic drive(input logic [6:0] op, input logic bc, input logic hr);
        opcode = op; bcond = bc; halt_req = hr;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // R-type with stray bcond/halt_req that must be ignored
        add(O_R, 1'b1, 1'b1, ST_IF, K_IR);
        add(O_R, 1'b1, 1'b1, ST_ID, K_IDST);
        add(O_R, 1'b1, 1'b1, ST_EX, K_APB);
        add(O_R, 1'b1, 1'b1, ST_WB, K_RFALU | K_PCP4);
        add(O_I, 1'b0, 1'b0, ST_IF, K_IR);
        add(O_I, 1'b0, 1'b0, ST_ID, K_IDST);
        add(O_I, 1'b0, 1'b0, ST_EX, K_APIMM);
        add(O_I, 1'b0, 1'b0, ST_WB, K_RFALU | K_PCP4);
        add(O_LD, 1'b0, 1'b0, ST_IF, K_IR);
        add(O_LD, 1'b0, 1'b0, ST_ID, K_IDST);
        add(O_LD, 1'b1, 1'b0, ST_EX, K_APIMM);
        add(O_LD, 1'b0, 1'b0, ST_MEM, K_MDR);
        add(O_LD, 1'b0, 1'b0, ST_WB, K_RFMDR | K_PCP4);
        add(O_ST, 1'b0, 1'b0, ST_IF, K_IR);
        add(O_ST, 1'b0, 1'b0, ST_ID, K_IDST);
        add(O_ST, 1'b0, 1'b0, ST_EX, K_APIMM);
        add(O_ST, 1'b0, 1'b0, ST_MEM, K_MEMB | K_PCP4);
        add(O_BR, 1'b1, 1'b0, ST_IF, K_IR);
        add(O_BR, 1'b1, 1'b0, ST_ID, K_IDST);
        add(O_BR, 1'b0, 1'b0, ST_EX, K_PCALU);
        add(O_BR, 1'b0, 1'b0, ST_IF, K_IR);
        add(O_BR, 1'b0, 1'b0, ST_ID, K_IDST);
        add(O_BR, 1'b1, 1'b0, ST_EX, K_PCALU);
        add(O_BR, 1'b0, 1'b0, ST_BRT, K_PCPIM);
        add(O_JAL, 1'b0, 1'b0, ST_IF, K_IR);
        add(O_JAL, 1'b0, 1'b0, ST_ID, K_IDST);
        add(O_JAL, 1'b1, 1'b0, ST_EX, K_RFALU | K_PCPIM);
        add(O_JR, 1'b0, 1'b0, ST_IF, K_IR);
        add(O_JR, 1'b0, 1'b0, ST_ID, K_IDST);
        add(O_JR, 1'b0, 1'b0, ST_EX, K_RFALU | K_PCAIM);
        add(O_EC, 1'b0, 1'b0, ST_IF, K_IR);
        add(O_EC, 1'b0, 1'b0, ST_ID, K_IDST);
        add(O_EC, 1'b0, 1'b1, ST_EX, K_PCP4);
        add(O_BAD, 1'b0, 1'b0, ST_IF, K_IR);
        add(O_BAD, 1'b0, 1'b1, ST_ID, K_IDST);
        add(O_BAD, 1'b1, 1'b0, ST_EX, K_PCP4);
        add(O_LD, 1'b0, 1'b0, ST_IF, K_IR);

        // Held in reset: strobes forced low even though state decodes as IF
        opcode = O_R;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("in_reset", ST_IF, 14'h0000, 1'b0);

        reset_n = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].bc, vecs[i].hr);
            if (i > 0 && vecs[i].st == ST_IF) exp_cnt = exp_cnt + 32'd1;
            check($sformatf("vec%0d", i), vecs[i].st, vecs[i].stb, vecs[i].hl);
            step();
        end

        // LOAD interrupted by reset in MEM
        drive(O_LD, 1'b0, 1'b0);
        check("ld_id", ST_ID, K_IDST, 1'b0);
        step();
        drive(O_LD, 1'b0, 1'b0);
        check("ld_ex", ST_EX, K_APIMM, 1'b0);
        step();
        drive(O_LD, 1'b0, 1'b0);
        check("ld_mem", ST_MEM, K_MDR, 1'b0);
        reset_n = 1'b0;
        exp_cnt = 32'd0;
        #1;
        check("ld_abort", ST_IF, 14'h0000, 1'b0);
        step();
        reset_n = 1'b1;
        #1;
        check("post_reset_if", ST_IF, K_IR, 1'b0);
        step();

        // Lands in ID after the first edge out of reset
        drive(O_EC, 1'b0, 1'b1);
        check("ec_id", ST_ID, K_IDST, 1'b0);
        step();
        for (int k = 0; k < 12; k++) begin
            drive(7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            check($sformatf("halt%0d", k), ST_HLT, 14'h0000, 1'b1);
            step();
        end

        reset_n = 1'b0;
        #1;
        check("halt_reset", ST_IF, 14'h0000, 1'b0);
        step();
        reset_n = 1'b1;
        drive(O_R, 1'b0, 1'b0);
        check("halt_exit_if", ST_IF, K_IR, 1'b0);
        step();
        drive(O_R, 1'b0, 1'b0);
        check("halt_exit_id", ST_ID, K_IDST, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
